// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access-size
// codes and the legality/alignment check used at issue.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // funct3 encodings; bit 2 selects zero-extension on loads
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic legal;
    logic aligned;
    if (is_store) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      SZ_B:    aligned = 1'b1;
      SZ_H:    aligned = ~off[0];
      default: aligned = (off == 2'b00);
    endcase
    return legal & aligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads. Purely combinational.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  always_comb begin
    st_be   = 4'b1111;
    st_data = st_wdata;
    case (st_funct3[1:0])
      SZ_B: begin
        st_be   = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_be   = 4'b0011 << st_off;
        st_data = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte   = rdata[{ld_off, 3'b000} +: 8];
  assign ld_half   = rdata[{ld_off[1], 4'b0000} +: 16];
  assign ld_signed = ~ld_funct3[2];

  always_comb begin
    ld_data = rdata;
    case (ld_funct3[1:0])
      SZ_B:    ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: issues one req/ack bus transaction per
// legal M-stage access and holds the pipeline until it completes.
//   state | meaning
//   IDLE  | waiting for an M-stage access; stall only while issuing
//   REQ   | bus_req high, fields frozen, waiting for bus_ack or timeout
//   DONE  | result/err pulses out, stall released so M advances
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_wr_m,
  input  logic        mem_rd_m,
  input  logic        flush_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic        stall_m,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       ld_f3;
  logic [1:0]       ld_off;
  logic             is_load;
  logic             access;
  logic             ok;
  logic             go;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic [31:0]      ld_ext;

  lsu_align u_align (
    .st_funct3 (funct3_m),
    .st_off    (addr_m[1:0]),
    .st_wdata  (wdata_m),
    .st_be     (st_be),
    .st_data   (st_data),
    .ld_funct3 (ld_f3),
    .ld_off    (ld_off),
    .rdata     (bus_rdata),
    .ld_data   (ld_ext)
  );

  assign access  = (mem_rd_m | mem_wr_m) & ~flush_m;
  assign ok      = access_ok(mem_wr_m, funct3_m, addr_m[1:0]);
  assign go      = (state == ST_IDLE) & access & ok;
  assign cnt_inc = cnt + 1'b1;

  // The issue cycle must stall combinationally so M holds at this edge.
  assign stall_m = reset & (go | (state == ST_REQ));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ld_f3        <= '0;
      ld_off       <= '0;
      is_load      <= 1'b0;
      ld_data      <= '0;
      ld_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
    end else begin
      ld_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_wr_m;
            bus_addr  <= {addr_m[31:2], 2'b00};
            bus_be    <= st_be;
            bus_wdata <= mem_wr_m ? st_data : 32'h0;
            is_load   <= ~mem_wr_m;
            ld_f3     <= funct3_m;
            ld_off    <= addr_m[1:0];
            cnt       <= '0;
            state     <= ST_REQ;
          end else if (access) begin
            misalign_err <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            ld_data  <= is_load ? ld_ext : 32'h0;
            ld_valid <= is_load;
            cnt      <= '0;
            state    <= ST_DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM)) begin
            bus_req <= 1'b0;
            ld_data <= 32'h0;
            bus_err <= 1'b1;
            cnt     <= '0;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
